// File: rtl/wb_sram_bank_ctrl.sv
// Wishbone classic slave in front of 1-4 byte-wide single-port SRAM macros.
// Bank b serves byte lane b of the 32-bit word; byte selects become bit write masks.
// Optional march BIST is compiled in when SRAM_BIST_EN is defined.
module wb_sram_bank_ctrl #(
  parameter int unsigned BANKS       = 4,
  parameter int unsigned BANK_AW     = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic                 err_clr_i,
  input  logic                 bist_start_i,
  output logic                 bist_done_o,
  output logic                 bist_fail_o,
  output logic [BANKS-1:0]     sram_cen_o,
  output logic [BANKS-1:0]     sram_gwen_o,
  output logic [8*BANKS-1:0]   sram_wen_o,
  output logic [BANK_AW-1:0]   sram_a_o,
  output logic [8*BANKS-1:0]   sram_d_o,
  input  logic [8*BANKS-1:0]   sram_q_i,
  output logic [2:0]           irq_o
);

  localparam int unsigned LW       = 8 * BANKS;
  localparam logic [2:0]  WaitLast = 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {StIdle, StAccess, StWait, StAck, StBist, StBistEnd} state_e;

  state_e               state_q, state_d;
  logic [BANK_AW-1:0]   adr_q;
  logic [31:0]          dat_q;
  logic [3:0]           sel_q;
  logic                 we_q;
  logic                 miss_q;
  logic [2:0]           wait_q;
  logic                 err_q;
  logic                 req, hit, bist_go, bist_irq;
  logic [31:0]          q_ext;

  assign req = wbs_cyc_i & wbs_stb_i;
  assign hit = (wbs_adr_i[31:BANK_AW+2] == BASE_ADDR[31:BANK_AW+2]);

`ifdef SRAM_BIST_EN
  logic [BANK_AW-1:0] bist_addr_q;
  logic [1:0]         bist_phase_q;   // 0: wr 55, 1: rd 55, 2: wr AA, 3: rd AA
  logic               bist_rd_vld_q;
  logic [7:0]         bist_rd_pat_q;
  logic               bist_done_q, bist_fail_q, bist_irq_q;
  logic [7:0]         bist_pat;

  assign bist_go     = bist_start_i;
  assign bist_pat    = bist_phase_q[1] ? 8'hAA : 8'h55;
  assign bist_done_o = bist_done_q;
  assign bist_fail_o = bist_fail_q;
  assign bist_irq    = bist_irq_q;

  // March sequencer: address/phase walk plus one-cycle-delayed read compare
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bist_addr_q   <= '0;
      bist_phase_q  <= 2'd0;
      bist_rd_vld_q <= 1'b0;
      bist_rd_pat_q <= 8'h00;
      bist_done_q   <= 1'b0;
      bist_fail_q   <= 1'b0;
      bist_irq_q    <= 1'b0;
    end else begin
      bist_irq_q    <= (state_q == StBistEnd);
      bist_rd_vld_q <= (state_q == StBist) && bist_phase_q[0];
      bist_rd_pat_q <= bist_pat;
      if (bist_rd_vld_q && (sram_q_i != {BANKS{bist_rd_pat_q}})) bist_fail_q <= 1'b1;
      if (state_q == StIdle && bist_go) begin
        bist_addr_q  <= '0;
        bist_phase_q <= 2'd0;
        bist_done_q  <= 1'b0;
        bist_fail_q  <= 1'b0;
      end else if (state_q == StBist) begin
        bist_addr_q <= bist_addr_q + 1'b1;
        if (bist_addr_q == '1) bist_phase_q <= bist_phase_q + 2'd1;
      end
      if (state_q == StBistEnd) bist_done_q <= 1'b1;
    end
  end
`else
  assign bist_go     = 1'b0;
  assign bist_done_o = 1'b0;
  assign bist_fail_o = 1'b0;
  assign bist_irq    = 1'b0;
`endif

  // State register and captured request; err flag with set-over-clear priority
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      adr_q   <= '0;
      dat_q   <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      miss_q  <= 1'b0;
      wait_q  <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= (state_q == StWait) ? wait_q + 3'd1 : 3'd0;
      if (state_q == StIdle && req && !bist_go) begin
        adr_q  <= wbs_adr_i[BANK_AW+1:2];
        dat_q  <= wbs_dat_i;
        sel_q  <= wbs_sel_i;
        we_q   <= wbs_we_i;
        miss_q <= !hit;
      end
      if (state_q == StIdle && req && !hit && !bist_go) err_q <= 1'b1;
      else if (err_clr_i)                               err_q <= 1'b0;
    end
  end

  // Next-state logic; a dropped cyc during ACCESS/WAIT abandons the ack
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bist_go)  state_d = StBist;
        else if (req) state_d = hit ? StAccess : StAck;
      end
      StAccess: begin
        if (!wbs_cyc_i)            state_d = StIdle;
        else if (WAIT_STATES == 0) state_d = StAck;
        else                       state_d = StWait;
      end
      StWait: begin
        if (!wbs_cyc_i)              state_d = StIdle;
        else if (wait_q == WaitLast) state_d = StAck;
      end
      StAck:     state_d = StIdle;
`ifdef SRAM_BIST_EN
      StBist:    if (bist_phase_q == 2'd3 && bist_addr_q == '1) state_d = StBistEnd;
`endif
      StBistEnd: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Macro strobes: idle outside ACCESS (and BIST); reads enable every populated lane
  always_comb begin
    sram_cen_o  = '1;
    sram_gwen_o = '1;
    sram_wen_o  = '1;
    sram_a_o    = adr_q;
    sram_d_o    = dat_q[LW-1:0];
    if (state_q == StAccess) begin
      for (int unsigned b = 0; b < BANKS; b++) begin
        if (!we_q) begin
          sram_cen_o[b] = 1'b0;
        end else if (sel_q[b]) begin
          sram_cen_o[b]       = 1'b0;
          sram_gwen_o[b]      = 1'b0;
          sram_wen_o[8*b +: 8] = 8'h00;
        end
      end
    end
`ifdef SRAM_BIST_EN
    if (state_q == StBist) begin
      sram_a_o   = bist_addr_q;
      sram_cen_o = '0;
      if (!bist_phase_q[0]) begin
        sram_gwen_o = '0;
        sram_wen_o  = '0;
        sram_d_o    = {BANKS{bist_pat}};
      end
    end
`endif
  end

  // Unpopulated byte lanes read as zero
  for (genvar g = 0; g < 4; g++) begin : g_lane
    if (g < BANKS) begin : g_pop
      assign q_ext[8*g +: 8] = sram_q_i[8*g +: 8];
    end else begin : g_empty
      assign q_ext[8*g +: 8] = 8'h00;
    end
  end

  assign wbs_ack_o = (state_q == StAck);
  assign wbs_dat_o = (wbs_ack_o && !we_q && !miss_q) ? q_ext : 32'h0;
  assign irq_o     = {bist_irq, err_q, wbs_ack_o & we_q};

  logic unused_ok;
`ifdef SRAM_BIST_EN
  assign unused_ok = ^{wbs_adr_i[1:0], dat_q, sel_q};
`else
  assign unused_ok = ^{wbs_adr_i[1:0], dat_q, sel_q, bist_start_i};
`endif

endmodule

// File: tb/tb_wb_sram_bank_ctrl.sv
// Bench for wb_sram_bank_ctrl: default instance (4 lanes, no wait states) and a
// 2-lane instance with 3 wait states, each driving a behavioural SRAM model.
module tb_wb_sram_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc0, cyc1, stb, we, err_clr, bist_start;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;

  logic        ack0, done0, fail0;
  logic [31:0] rdat0, wen0, d0, q0;
  logic [3:0]  cen0, gwen0;
  logic [9:0]  a0;
  logic [2:0]  irqv0;

  logic        ack1, done1, fail1;
  logic [31:0] rdat1;
  logic [15:0] wen1, d1, q1;
  logic [1:0]  cen1, gwen1;
  logic [9:0]  a1;
  logic [2:0]  irqv1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_sram_bank_ctrl dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack0), .wbs_dat_o(rdat0),
    .err_clr_i(err_clr), .bist_start_i(bist_start), .bist_done_o(done0), .bist_fail_o(fail0),
    .sram_cen_o(cen0), .sram_gwen_o(gwen0), .sram_wen_o(wen0), .sram_a_o(a0), .sram_d_o(d0),
    .sram_q_i(q0), .irq_o(irqv0)
  );

  wb_sram_bank_ctrl #(.BANKS(2), .WAIT_STATES(3)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc1), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack1), .wbs_dat_o(rdat1),
    .err_clr_i(err_clr), .bist_start_i(bist_start), .bist_done_o(done1), .bist_fail_o(fail1),
    .sram_cen_o(cen1), .sram_gwen_o(gwen1), .sram_wen_o(wen1), .sram_a_o(a1), .sram_d_o(d1),
    .sram_q_i(q1), .irq_o(irqv1)
  );

  // Behavioural macros: registered read, bit-masked write; optional stuck-at-0 on lane 1 bit 0
  logic [7:0] mem0 [4][1024];
  logic [7:0] mem1 [2][1024];
  logic       stuck = 1'b0;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!cen0[b]) begin
        if (!gwen0[b]) mem0[b][a0] <= (mem0[b][a0] & wen0[8*b +: 8]) | (d0[8*b +: 8] & ~wen0[8*b +: 8]);
        else           q0[8*b +: 8] <= mem0[b][a0] & ((stuck && b == 1) ? 8'hFE : 8'hFF);
      end
    end
    for (int b = 0; b < 2; b++) begin
      if (!cen1[b]) begin
        if (!gwen1[b]) mem1[b][a1] <= (mem1[b][a1] & wen1[8*b +: 8]) | (d1[8*b +: 8] & ~wen1[8*b +: 8]);
        else           q1[8*b +: 8] <= mem1[b][a1];
      end
    end
  end

  // Activity monitors sampled mid-cycle
  int         cen_cnt0, cen_cnt1, wirq0, wirq1, irq2_cnt, ack_cnt0, ack_cnt1;
  logic [3:0] gwen_seen0;
  logic [9:0] a_seen0;

  initial begin
    cen_cnt0 = 0; cen_cnt1 = 0; wirq0 = 0; wirq1 = 0; irq2_cnt = 0;
    ack_cnt0 = 0; ack_cnt1 = 0; gwen_seen0 = 4'h0; a_seen0 = 10'h0;
  end

  always @(negedge clk) begin
    if (cen0 != 4'hF) begin cen_cnt0++; a_seen0 = a0; end
    if (cen1 != 2'b11) cen_cnt1++;
    gwen_seen0 = gwen_seen0 | ~gwen0;
    if (irqv0[0]) wirq0++;
    if (irqv1[0]) wirq1++;
    if (irqv0[2]) irq2_cnt++;
    if (ack0) ack_cnt0++;
    if (ack1) ack_cnt1++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard of expected transaction results
  typedef struct {
    logic [31:0] dat;
    int          lat;
    int          irq;
  } exp_t;
  exp_t exp_q[$];

  task automatic xfer(input int dn, input logic w, input logic [31:0] ad, input logic [3:0] s,
                      input logic [31:0] wd, input logic [31:0] ed, input int el, input int ei,
                      input string nm);
    exp_t        e;
    int          k;
    logic        got;
    logic [31:0] rd;
    e.dat = ed; e.lat = el; e.irq = ei;
    exp_q.push_back(e);
    @(negedge clk); #1;
    cen_cnt0 = 0; cen_cnt1 = 0; gwen_seen0 = 4'h0; wirq0 = 0; wirq1 = 0;
    we = w; adr = ad; sel = s; wdat = wd; stb = 1'b1;
    if (dn == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
    k = 0; got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk); #1;
      k++;
      got = (dn == 0) ? ack0 : ack1;
    end
    rd = (dn == 0) ? rdat0 : rdat1;
    cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0;
    e = exp_q.pop_front();
    chk({nm, " ack"}, {31'b0, got}, 32'd1);
    chk({nm, " lat"}, 32'(k), 32'(e.lat));
    chk({nm, " dat"}, rd, e.dat);
    @(negedge clk); #1;
    chk({nm, " ack pulse"}, {31'b0, (dn == 0) ? ack0 : ack1}, 32'd0);
    chk({nm, " wirq"}, 32'((dn == 0) ? wirq0 : wirq1), 32'(e.irq));
  endtask

  task automatic pulse_clr();
    @(negedge clk); #1; err_clr = 1'b1;
    @(negedge clk); #1; err_clr = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] ad;
    logic [3:0]  s;
    logic [31:0] wd;
    logic [31:0] ed;
    int          lat;
    int          irq;
    int          cen;
    logic [3:0]  gw;
    logic [9:0]  a;
    logic        err;
    logic        clr;
  } vec_t;

  vec_t vt[12];

  initial begin
    int k;
    int a_before;
    vt[0]  = '{1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,         2, 1, 1, 4'hF, 10'h004, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 2, 0, 1, 4'h0, 10'h004, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 32'h3000_0020, 4'hF, 32'h1122_3344, 32'h0,         2, 1, 1, 4'hF, 10'h008, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 32'h3000_0020, 4'h5, 32'hAABB_CCDD, 32'h0,         2, 1, 1, 4'h5, 10'h008, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 32'h3000_0020, 4'h0, 32'h0,         32'h11BB_33DD, 2, 0, 1, 4'h0, 10'h008, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 32'h3001_0000, 4'hF, 32'h0,         32'h0,         1, 0, 0, 4'h0, 10'h000, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 32'h3000_0FFC, 4'hF, 32'h0102_0304, 32'h0,         2, 1, 1, 4'hF, 10'h3FF, 1'b1, 1'b1};
    vt[7]  = '{1'b0, 32'h3000_0FFF, 4'hF, 32'h0,         32'h0102_0304, 2, 0, 1, 4'h0, 10'h3FF, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 32'h3000_1000, 4'hF, 32'h0,         32'h0,         1, 0, 0, 4'h0, 10'h000, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 32'h2FFF_FFFC, 4'hF, 32'h0,         32'h0,         1, 0, 0, 4'h0, 10'h000, 1'b1, 1'b1};
    vt[10] = '{1'b1, 32'h3000_0010, 4'h8, 32'h7700_0000, 32'h0,         2, 1, 1, 4'h8, 10'h004, 1'b0, 1'b0};
    vt[11] = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         32'h77AD_BEEF, 2, 0, 1, 4'h0, 10'h004, 1'b0, 1'b0};

    rst = 1'b1; cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; wdat = 32'h0; err_clr = 1'b0; bist_start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;

    // Reset state
    chk("rst ack",  {31'b0, ack0}, 32'd0);
    chk("rst dat",  rdat0, 32'h0);
    chk("rst cen",  {28'b0, cen0}, 32'hF);
    chk("rst gwen", {28'b0, gwen0}, 32'hF);
    chk("rst wen",  wen0, 32'hFFFF_FFFF);
    chk("rst a",    {22'b0, a0}, 32'h0);
    chk("rst d",    d0, 32'h0);
    chk("rst irq",  {29'b0, irqv0}, 32'h0);
    chk("rst bist", {30'b0, done0, fail0}, 32'h0);

    // Table-driven single transfers on the 4-lane instance
    for (int i = 0; i < 12; i++) begin
      xfer(0, vt[i].w, vt[i].ad, vt[i].s, vt[i].wd, vt[i].ed, vt[i].lat, vt[i].irq,
           $sformatf("v%0d", i));
      chk($sformatf("v%0d cen", i), 32'(cen_cnt0), 32'(vt[i].cen));
      chk($sformatf("v%0d gwen", i), {28'b0, gwen_seen0}, {28'b0, vt[i].gw});
      if (vt[i].cen != 0) chk($sformatf("v%0d addr", i), {22'b0, a_seen0}, {22'b0, vt[i].a});
      chk($sformatf("v%0d err", i), {31'b0, irqv0[1]}, {31'b0, vt[i].err});
      if (vt[i].clr) pulse_clr();
    end

    // Miss with clear asserted on the same edge: set wins
    @(negedge clk); #1;
    adr = 32'h3002_0000; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc0 = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("setwin ack", {31'b0, ack0}, 32'd1);
    cyc0 = 1'b0; stb = 1'b0;
    @(negedge clk); #1;
    chk("setwin err", {31'b0, irqv0[1]}, 32'd1);
    pulse_clr();
    chk("clr err", {31'b0, irqv0[1]}, 32'd0);

    // Abort a write during ACCESS: no ack, no write irq, macro write still lands
    @(negedge clk); #1;
    cen_cnt0 = 0; wirq0 = 0; a_before = ack_cnt0;
    adr = 32'h3000_0030; we = 1'b1; sel = 4'hF; wdat = 32'hCAFE_F00D; stb = 1'b1; cyc0 = 1'b1;
    @(negedge clk); #1;
    cyc0 = 1'b0; stb = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("abort ack", 32'(ack_cnt0 - a_before), 32'd0);
    chk("abort wirq", 32'(wirq0), 32'd0);
    chk("abort cen", 32'(cen_cnt0), 32'd1);
    xfer(0, 1'b0, 32'h3000_0030, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 0, "after abort");

    // Two-lane instance with wait states: upper lanes dropped on write, zero on read
    xfer(1, 1'b1, 32'h3000_0000, 4'hF, 32'h1234_A5C3, 32'h0, 5, 1, "ws wr");
    xfer(1, 1'b0, 32'h3000_0000, 4'hF, 32'h0, 32'h0000_A5C3, 5, 0, "ws rd");
    chk("ws rd cen", 32'(cen_cnt1), 32'd1);

    // Abort during WAIT on the wait-state instance
    @(negedge clk); #1;
    a_before = ack_cnt1;
    adr = 32'h3000_0000; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc1 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    cyc1 = 1'b0; stb = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("ws abort ack", 32'(ack_cnt1 - a_before), 32'd0);
    xfer(1, 1'b0, 32'h3000_0000, 4'hF, 32'h0, 32'h0000_A5C3, 5, 0, "ws after abort");

`ifdef SRAM_BIST_EN
    // BIST with a good model, with a WB read queued behind it
    irq2_cnt = 0;
    @(negedge clk); #1; bist_start = 1'b1;
    @(negedge clk); #1; bist_start = 1'b0;
    chk("bist busy done", {31'b0, done0}, 32'd0);
    adr = 32'h3000_0010; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc0 = 1'b1;
    k = 0;
    while (!ack0 && k < 6000) begin @(negedge clk); #1; k++; end
    chk("bist wb ack", {31'b0, ack0}, 32'd1);
    chk("bist wb after done", {31'b0, done0}, 32'd1);
    chk("bist wb dat", rdat0, 32'hAAAA_AAAA);
    cyc0 = 1'b0; stb = 1'b0;
    @(negedge clk); #1;
    chk("bist fail good", {31'b0, fail0}, 32'd0);
    chk("bist irq2", 32'(irq2_cnt), 32'd1);

    // Stuck-at-0 on lane 1
    stuck = 1'b1;
    @(negedge clk); #1; bist_start = 1'b1;
    @(negedge clk); #1; bist_start = 1'b0;
    k = 0;
    while (!done0 && k < 6000) begin @(negedge clk); #1; k++; end
    chk("bist2 done", {31'b0, done0}, 32'd1);
    chk("bist2 fail", {31'b0, fail0}, 32'd1);
    @(negedge clk); #1;
    chk("bist2 irq2", 32'(irq2_cnt), 32'd2);
    stuck = 1'b0;
`else
    // BIST absent: trigger has no effect
    irq2_cnt = 0;
    @(negedge clk); #1; bist_start = 1'b1;
    @(negedge clk); #1; bist_start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("nobist done", {31'b0, done0}, 32'd0);
    chk("nobist fail", {31'b0, fail0}, 32'd0);
    chk("nobist irq2", 32'(irq2_cnt), 32'd0);
    xfer(0, 1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'h77AD_BEEF, 2, 0, "nobist rd");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
